// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Accepts one retired instruction per
// handshake. It drives the register-file and data-memory write ports and holds
// the architectural flag register {zero,carry,ac,parity}. MUL/DIV results are
// written as two bytes into rd and rd+1 over two cycles. HALT stops the pipe
// until reset.
// Optional feature macro: WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass
// outputs that show the pending register write.
module writeback_stage #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int MEM_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            opcode,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [2*DATA_W-1:0]   result,
    input  logic                  zero_in,
    input  logic                  carry_in,
    input  logic                  ac_in,
    input  logic                  parity_in,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [3:0]            flags,
    output logic                  wb_done,
    output logic                  halted
`ifdef WB_FWD_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [4:0] OP_MUL   = 5'b00011;
    localparam logic [4:0] OP_DIV   = 5'b00100;
    localparam logic [4:0] OP_LOAD  = 5'b01011;
    localparam logic [4:0] OP_STORE = 5'b01100;
    localparam logic [4:0] OP_CMP   = 5'b11001;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    // ALU/load class: one register write of the low result byte.
    function automatic logic is_rf_single(input logic [4:0] op);
        return (op <= 5'b00010) ||
               ((op >= 5'b00101) && (op <= 5'b01011)) ||
               ((op >= 5'b10000) && (op <= 5'b10101));
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Flags are architecturally updated by ALU ops (not load), MUL, DIV and compare.
    function automatic logic loads_flags(input logic [4:0] op);
        return (is_rf_single(op) && (op != OP_LOAD)) || is_muldiv(op) || (op == OP_CMP);
    endfunction

    state_t                  state_q, state_d;
    logic [4:0]              op_q, op_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
    logic [2*DATA_W-1:0]     res_q, res_d;
    logic                    rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]       rf_wdata_q, rf_wdata_d;
    logic                    mem_we_q, mem_we_d;
    logic [MEM_ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
    logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]              flags_q, flags_d;
    logic                    wb_done_q, wb_done_d;
    logic                    halted_q, halted_d;

    // Next-state, input latch and registered-output computation.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        res_d       = res_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        flags_d     = flags_q;
        wb_done_d   = 1'b0;
        halted_d    = halted_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d   = opcode;
                    rd_d   = rd;
                    addr_d = mem_addr;
                    res_d  = result;
                    if (loads_flags(opcode)) begin
                        flags_d = {zero_in, carry_in, ac_in, parity_in};
                    end else begin
                        flags_d = flags_q;
                    end
                    if (opcode == OP_HALT) begin
                        state_d   = HALT;
                        wb_done_d = 1'b1;
                    end else begin
                        state_d = WR_LO;
                        if (is_rf_single(opcode) || is_muldiv(opcode)) begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = rd;
                            rf_wdata_d = result[DATA_W-1:0];
                            // MUL/DIV retire only after the high byte.
                            wb_done_d  = !is_muldiv(opcode);
                        end else if (opcode == OP_STORE) begin
                            mem_we_d    = 1'b1;
                            mem_waddr_d = mem_addr;
                            mem_wdata_d = result[DATA_W-1:0];
                            wb_done_d   = 1'b1;
                        end else begin
                            wb_done_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR_LO: begin
                if (is_muldiv(op_q)) begin
                    state_d    = WR_HI;
                    rf_we_d    = 1'b1;
                    rf_waddr_d = rd_q + REG_ADDR_W'(1);
                    rf_wdata_d = res_q[2*DATA_W-1:DATA_W];
                    wb_done_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_HI: begin
                state_d = IDLE;
            end
            HALT: begin
                state_d  = HALT;
                halted_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latch and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= 5'b00000;
            rd_q        <= '0;
            addr_q      <= '0;
            res_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            flags_q     <= 4'b0000;
            wb_done_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            res_q       <= res_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            flags_q     <= flags_d;
            wb_done_q   <= wb_done_d;
            halted_q    <= halted_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign flags     = flags_q;
    assign wb_done   = wb_done_q;
    assign halted    = halted_q;

`ifdef WB_FWD_EN
    // Bypass view of the register write presented this cycle, taken from the latch.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_rd    = '0;
        fwd_data  = '0;
        if ((state_q == WR_LO) && (is_rf_single(op_q) || is_muldiv(op_q))) begin
            fwd_valid = 1'b1;
            fwd_rd    = rd_q;
            fwd_data  = res_q[DATA_W-1:0];
        end else if (state_q == WR_HI) begin
            fwd_valid = 1'b1;
            fwd_rd    = rd_q + REG_ADDR_W'(1);
            fwd_data  = res_q[2*DATA_W-1:DATA_W];
        end else begin
            fwd_valid = 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage. Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [2:0]  rd;
    logic [3:0]  mem_addr;
    logic [15:0] result;
    logic [3:0]  fl_in;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic        mem_we;
    logic [3:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [3:0]  flags;
    logic        wb_done;
    logic        halted;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [2:0]  fwd_rd;
    logic [7:0]  fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rd        (rd),
        .mem_addr  (mem_addr),
        .result    (result),
        .zero_in   (fl_in[3]),
        .carry_in  (fl_in[2]),
        .ac_in     (fl_in[1]),
        .parity_in (fl_in[0]),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .flags     (flags),
        .wb_done   (wb_done),
        .halted    (halted)
`ifdef WB_FWD_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one instruction for a single accepting edge; returns at the
    // falling edge of the first output cycle.
    task automatic send(input logic [4:0] op, input logic [2:0] r, input logic [3:0] a,
                        input logic [15:0] res, input logic [3:0] f);
        opcode   = op;
        rd       = r;
        mem_addr = a;
        result   = res;
        fl_in    = f;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        opcode   = 5'b00000;
        rd       = 3'd0;
        mem_addr = 4'd0;
        result   = 16'h0000;
        fl_in    = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        // Reset state: {rf_we,mem_we,wb_done,halted,flags,rf_waddr,rf_wdata,mem_waddr,mem_wdata}
        check_eq("reset_outs", {rf_we, mem_we, wb_done, halted, flags, rf_waddr, rf_wdata,
                                mem_waddr, mem_wdata}, 32'h0);
        check_eq("reset_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // ADD r3 <= A5, flags 0100
        send(5'b00001, 3'd3, 4'd0, 16'h00A5, 4'b0100);
        check_eq("add_wr", {rf_we, rf_waddr, rf_wdata, wb_done, mem_we}, {21'd0, 1'b1, 3'd3, 8'hA5, 1'b1, 1'b0});
        check_eq("add_flags", {28'd0, flags}, 32'h4);
        check_eq("add_busy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check_eq("add_idle", {rf_we, wb_done, in_ready}, {29'd0, 3'b001});

        // MUL r7 <= 1234: low to r7, high wraps to r0
        send(5'b00011, 3'd7, 4'd0, 16'h1234, 4'b1010);
        check_eq("mul_lo", {rf_we, rf_waddr, rf_wdata, wb_done}, {20'd0, 1'b1, 3'd7, 8'h34, 1'b0});
        check_eq("mul_flags", {28'd0, flags}, 32'hA);
`ifdef WB_FWD_EN
        check_eq("mul_fwd_lo", {fwd_valid, fwd_rd, fwd_data}, {20'd0, 1'b1, 3'd7, 8'h34});
`endif
        @(negedge clk);
        check_eq("mul_hi", {rf_we, rf_waddr, rf_wdata, wb_done}, {20'd0, 1'b1, 3'd0, 8'h12, 1'b1});
        @(negedge clk);
        check_eq("mul_end", {rf_we, wb_done, in_ready}, {29'd0, 3'b001});

        // STORE: memory write only, flags held at 1010
        send(5'b01100, 3'd5, 4'hC, 16'h995A, 4'b1111);
        check_eq("st_wr", {mem_we, mem_waddr, mem_wdata, rf_we, wb_done}, {18'd0, 1'b1, 4'hC, 8'h5A, 1'b0, 1'b1});
        check_eq("st_flags", {28'd0, flags}, 32'hA);
        @(negedge clk);
        check_eq("st_end", {mem_we, wb_done, in_ready}, {29'd0, 3'b001});

        // LOAD: register write, flags held
        send(5'b01011, 3'd1, 4'd0, 16'h00C3, 4'b0001);
        check_eq("ld_wr", {rf_we, rf_waddr, rf_wdata, wb_done}, {20'd0, 1'b1, 3'd1, 8'hC3, 1'b1});
        check_eq("ld_flags", {28'd0, flags}, 32'hA);
        @(negedge clk);

        // Jump: no writes, flags held
        send(5'b01101, 3'd2, 4'd3, 16'hFFFF, 4'b0101);
        check_eq("jmp", {rf_we, mem_we, wb_done, flags}, {25'd0, 3'b001, 4'hA});
        @(negedge clk);

        // Compare: no writes, flags loaded
        send(5'b11001, 3'd2, 4'd3, 16'h0000, 4'b0011);
        check_eq("cmp", {rf_we, mem_we, wb_done, flags}, {25'd0, 3'b001, 4'h3});
        @(negedge clk);

        // Unknown opcode: no-op retire, flags held
        send(5'b11010, 3'd4, 4'd4, 16'h4444, 4'b1100);
        check_eq("unk", {rf_we, mem_we, wb_done, flags}, {25'd0, 3'b001, 4'h3});
        @(negedge clk);

        // DIV r2 <= 0307 full sequence
        send(5'b00100, 3'd2, 4'd0, 16'h0307, 4'b1001);
        check_eq("div_lo", {rf_we, rf_waddr, rf_wdata, wb_done}, {20'd0, 1'b1, 3'd2, 8'h07, 1'b0});
`ifdef WB_FWD_EN
        check_eq("div_fwd_lo", {fwd_valid, fwd_rd, fwd_data}, {20'd0, 1'b1, 3'd2, 8'h07});
`endif
        @(negedge clk);
        check_eq("div_hi", {rf_we, rf_waddr, rf_wdata, wb_done, flags}, {16'd0, 1'b1, 3'd3, 8'h03, 1'b1, 4'h9});
`ifdef WB_FWD_EN
        check_eq("div_fwd_hi", {fwd_valid, fwd_rd, fwd_data}, {20'd0, 1'b1, 3'd3, 8'h03});
`endif
        @(negedge clk);
`ifdef WB_FWD_EN
        check_eq("div_fwd_off", {fwd_valid, fwd_rd, fwd_data}, 32'd0);
`endif
        check_eq("div_end", {rf_we, in_ready}, {30'd0, 2'b01});

        // DIV aborted by reset before the high-byte write
        send(5'b00100, 3'd5, 4'd0, 16'hBEEF, 4'b1111);
        check_eq("abort_lo", {rf_we, rf_waddr, rf_wdata}, {20'd0, 1'b1, 3'd5, 8'hEF});
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_outs", {rf_we, mem_we, wb_done, halted, flags, rf_waddr, rf_wdata,
                                mem_waddr, mem_wdata}, 32'h0);
        check_eq("abort_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // HALT then an ADD held on the input for 10 cycles
        send(5'b11111, 3'd0, 4'd0, 16'h0000, 4'b0000);
        check_eq("halt_done", {wb_done, halted, in_ready}, {29'd0, 3'b100});
        opcode   = 5'b00001;
        rd       = 3'd6;
        result   = 16'h0077;
        fl_in    = 4'b1111;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("halt_hold", {halted, in_ready, rf_we, mem_we, wb_done, flags},
                     {23'd0, 5'b10000, 4'h0});
        end
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
